// File: rtl/cpu_pkg.sv
// Shared RV32 core types and constants used by the fetch and decode stages.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    pc4;
        logic [INSTR_W-1:0] instr;
    } ifid_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the ROM, fills IF/ID,
// and handles stall, redirect-with-flush and the halt word.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [INSTR_W-1:0]  rom_instr,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                ifid_valid_o,
    output logic [XLEN-1:0]     ifid_pc_o,
    output logic [XLEN-1:0]     ifid_pc4_o,
    output logic [INSTR_W-1:0]  ifid_instr_o,
    output logic                halted_o
);

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);

    logic [XLEN-1:0] pc_q, pc_d;
    fetch_state_t    state_q, state_d;
    ifid_t           ifid_q, ifid_d;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + PC_STEP;

    // Word address wraps modulo the ROM depth; pc itself stays full width.
    assign rom_addr = pc_q[ADDR_W+1:2];

    // Next-state selection by priority: redirect, stall, run/halt.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        ifid_d  = ifid_q;
        if (redirect_i) begin
            pc_d         = redirect_pc_i & ALIGN_MSK;
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
            state_d      = RUN;
        end else if (!stall_i) begin
            if (state_q == RUN) begin
                ifid_d = '{valid: 1'b1, pc: pc_q, pc4: pc_plus4, instr: rom_instr};
                if (rom_instr == HALT_INSTR) begin
                    // Halt word drains down the pipe; fetch parks on it.
                    state_d = HALTED;
                end else begin
                    pc_d = pc_plus4;
                end
            end else begin
                ifid_d.valid = 1'b0;
                ifid_d.instr = NOP_INSTR;
            end
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            ifid_q  <= '{valid: 1'b0, pc: '0, pc4: PC_STEP, instr: NOP_INSTR};
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            ifid_q  <= ifid_d;
        end
    end

    assign ifid_valid_o = ifid_q.valid;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_pc4_o   = ifid_q.pc4;
    assign ifid_instr_o = ifid_q.instr;
    assign halted_o     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus a randomized run checked against a behavioural model.
module tb_fetch_stage;

    localparam int unsigned AW = 5;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_instr;
    logic          stall_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          ifid_valid_o;
    logic [31:0]   ifid_pc_o;
    logic [31:0]   ifid_pc4_o;
    logic [31:0]   ifid_instr_o;
    logic          halted_o;

    logic [31:0] rom [32];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural view of the fetch stage
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_valid;
    logic [31:0] m_ipc, m_ipc4, m_instr;

    always #5 clk = ~clk;

    assign rom_instr = rom[rom_addr];

    fetch_stage #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr      (rom_addr),
        .rom_instr     (rom_instr),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_instr_o  (ifid_instr_o),
        .halted_o      (halted_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the inputs it sees.
    always @(posedge clk) begin
        logic [31:0] word;
        word = rom[m_pc[AW+1:2]];
        if (rst) begin
            m_pc = 32'h0; m_halted = 0; m_valid = 0;
            m_ipc = 32'h0; m_ipc4 = 32'h4; m_instr = NOP;
        end else if (redirect_i) begin
            m_pc = {redirect_pc_i[31:2], 2'b00};
            m_valid = 0; m_instr = NOP; m_halted = 0;
        end else if (stall_i) begin
            m_pc = m_pc;
        end else if (m_halted) begin
            m_valid = 0; m_instr = NOP;
        end else begin
            m_valid = 1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = word;
            if (word == HALT) m_halted = 1;
            else m_pc = m_pc + 32'd4;
        end
        chk_en = 1'b1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_rom_addr", 32'(rom_addr), 32'(m_pc[AW+1:2]));
            check("m_valid",    32'(ifid_valid_o), 32'(m_valid));
            check("m_pc",       ifid_pc_o, m_ipc);
            check("m_pc4",      ifid_pc4_o, m_ipc4);
            check("m_instr",    ifid_instr_o, m_instr);
            check("m_halted",   32'(halted_o), 32'(m_halted));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; stall_i = 0; redirect_i = 0;
        cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 32'h0;
        for (int i = 0; i < 32; i++) rom[i] = NOP;
        rom[0] = 32'h0050_0513;
        rom[1] = 32'h00c0_00ef;
        rom[2] = 32'h00a0_2023;
        rom[3] = HALT;
        rom[4] = 32'hff81_0113;

        // Scenario 1: straight-line fetch into the halt word
        do_reset();
        check("rst_valid", 32'(ifid_valid_o), 32'h0);
        check("rst_pc4", ifid_pc4_o, 32'h4);
        check("rst_instr", ifid_instr_o, NOP);
        check("rst_addr", 32'(rom_addr), 32'h0);
        cyc();
        check("s1_pc0", ifid_pc_o, 32'h0);
        check("s1_i0", ifid_instr_o, 32'h0050_0513);
        cyc();
        check("s1_pc4", ifid_pc_o, 32'h4);
        check("s1_i1", ifid_instr_o, 32'h00c0_00ef);
        cyc();
        check("s1_pc8", ifid_pc_o, 32'h8);
        check("s1_i2", ifid_instr_o, 32'h00a0_2023);
        cyc();
        check("s1_pc12", ifid_pc_o, 32'hC);
        check("s1_halt_word", ifid_instr_o, HALT);
        check("s1_halt_valid", 32'(ifid_valid_o), 32'h1);
        cyc();
        check("s1_halted", 32'(halted_o), 32'h1);
        check("s1_bubble", 32'(ifid_valid_o), 32'h0);
        check("s1_addr_hold", 32'(rom_addr), 32'h3);

        // Scenario 4: redirect out of HALTED
        redirect_i = 1; redirect_pc_i = 32'h10;
        cyc();
        redirect_i = 0;
        check("s4_unhalt", 32'(halted_o), 32'h0);
        check("s4_addr", 32'(rom_addr), 32'h4);
        cyc();
        check("s4_resume_pc", ifid_pc_o, 32'h10);
        check("s4_resume_i", ifid_instr_o, 32'hff81_0113);

        // Scenario 2: two-cycle stall at pc=8
        do_reset();
        cyc(); cyc();
        stall_i = 1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("s2_hold_pc", ifid_pc_o, 32'h4);
            check("s2_hold_addr", 32'(rom_addr), 32'h2);
        end
        stall_i = 0;
        cyc();
        check("s2_release", ifid_pc_o, 32'h8);

        // Scenario 3: redirect while pc=8
        do_reset();
        cyc(); cyc();
        redirect_i = 1; redirect_pc_i = 32'h10;
        cyc();
        redirect_i = 0;
        check("s3_flush_v", 32'(ifid_valid_o), 32'h0);
        check("s3_flush_i", ifid_instr_o, NOP);
        check("s3_addr", 32'(rom_addr), 32'h4);
        cyc();
        check("s3_pc", ifid_pc_o, 32'h10);
        check("s3_pc4", ifid_pc4_o, 32'h14);
        check("s3_i", ifid_instr_o, 32'hff81_0113);

        // Scenario 5: redirect beats stall, target misaligned
        redirect_i = 1; stall_i = 1; redirect_pc_i = 32'h2E;
        cyc();
        redirect_i = 0; stall_i = 0;
        check("s5_addr", 32'(rom_addr), 32'hB);
        check("s5_flush", 32'(ifid_valid_o), 32'h0);
        cyc();
        check("s5_pc", ifid_pc_o, 32'h2C);

        // Scenario 6: reset during a stall
        stall_i = 1; rst = 1;
        cyc();
        rst = 0; stall_i = 0;
        check("s6_addr", 32'(rom_addr), 32'h0);
        check("s6_valid", 32'(ifid_valid_o), 32'h0);
        check("s6_halted", 32'(halted_o), 32'h0);
        check("s6_pc4", ifid_pc4_o, 32'h4);

        // Randomized run against the model
        for (int i = 0; i < 32; i++)
            rom[i] = ($urandom_range(7) == 0) ? HALT : $urandom;
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(199) == 0);
            stall_i    = ($urandom_range(4) == 0);
            redirect_i = ($urandom_range(9) == 0);
            case ($urandom_range(3))
                0:       redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                1:       redirect_pc_i = $urandom;
                default: redirect_pc_i = 32'($urandom_range(127));
            endcase
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
